// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one iterative multiplier among requesters
module mul_share_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    parameter int  TIMEOUT = 64,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_overflow,
    output logic                     resp_timeout,
    output logic                     busy,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done,
    input  logic                     mul_overflow,
    output logic                     mul_rst
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RECOVER,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    op_id;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    next_ptr;
    logic               grant_found;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [CNT_W-1:0]   wd_cnt;
    logic               rec_cnt;
    logic               timeout_hit;
    logic [2*WIDTH-1:0] res_prod;
    logic               res_ovf, res_tmo;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign next_ptr    = (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (grant_found) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT: begin
                // done takes priority over a coincident watchdog expiry
                if (mul_done)         state_d = S_RESP;
                else if (timeout_hit) state_d = S_RECOVER;
            end
            S_RECOVER: if (rec_cnt) state_d = S_RESP;
            S_RESP:    if (resp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) req_ready[grant_id] = 1'b1;
    end

    assign busy             = (state_q != S_IDLE);
    assign mul_start        = (state_q == S_ISSUE);
    assign mul_rst          = !rst || (state_q == S_RECOVER);
    assign mul_multiplicand = op_a;
    assign mul_multiplier   = op_b;
    assign resp_valid       = (state_q == S_RESP);
    assign resp_id          = op_id;
    assign resp_product     = res_prod;
    assign resp_overflow    = res_ovf;
    assign resp_timeout     = res_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            op_id    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            wd_cnt   <= '0;
            rec_cnt  <= 1'b0;
            res_prod <= '0;
            res_ovf  <= 1'b0;
            res_tmo  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        op_a  <= req_a[grant_id*WIDTH +: WIDTH];
                        op_b  <= req_b[grant_id*WIDTH +: WIDTH];
                        op_id <= grant_id;
                    end
                end
                S_ISSUE: wd_cnt <= '0;
                S_WAIT: begin
                    wd_cnt  <= wd_cnt + CNT_W'(1);
                    rec_cnt <= 1'b0;
                    if (mul_done) begin
                        res_prod <= mul_product;
                        res_ovf  <= mul_overflow;
                        res_tmo  <= 1'b0;
                    end else if (timeout_hit) begin
                        res_prod <= '0;
                        res_ovf  <= 1'b0;
                        res_tmo  <= 1'b1;
                    end
                end
                S_RECOVER: rec_cnt <= 1'b1;
                S_RESP:    if (resp_ready) rr_ptr <= next_ptr;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter with a multiplier stub
module tb_mul_share_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*W-1:0] req_a, req_b;
    logic            resp_valid, resp_ready;
    logic [1:0]      resp_id;
    logic [2*W-1:0]  resp_product;
    logic            resp_overflow, resp_timeout, busy, mul_start;
    logic [W-1:0]    mul_multiplicand, mul_multiplier;
    logic [2*W-1:0]  mul_product = '0;
    logic            mul_done, mul_overflow = 1'b0, mul_rst;

    mul_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product), .resp_overflow(resp_overflow), .resp_timeout(resp_timeout),
        .busy(busy), .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product), .mul_done(mul_done), .mul_overflow(mul_overflow),
        .mul_rst(mul_rst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    endfunction

    // Multiplier stub: done after stub_lat cycles, never when hung; cleared by mul_rst.
    logic        stub_hang = 1'b0, stub_busy = 1'b0, stub_done = 1'b0, spur_done = 1'b0;
    int          stub_lat = 1, stub_cnt = 0;
    logic [31:0] pa = '0, pb = '0;
    logic [63:0] sp;
    assign mul_done = stub_done | spur_done;
    assign sp = smul(pa, pb);

    always @(posedge clk) begin
        if (mul_rst) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (mul_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= stub_lat;
                pa        <= mul_multiplicand;
                pb        <= mul_multiplier;
            end else if (stub_busy && !stub_hang) begin
                if (stub_cnt <= 1) begin
                    stub_done    <= 1'b1;
                    stub_busy    <= 1'b0;
                    mul_product  <= sp;
                    mul_overflow <= ~((&sp[63:31]) | ~(|sp[63:31]));
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int          id;
        logic [63:0] prod;
        logic        ovf;
        logic        tmo;
    } exp_t;
    exp_t sb[$];

    int   cyc = 0;
    int   start_cyc = 0, rv_cyc = 0, start_cnt = 0, rdy_cnt = 0, mrst_cnt = 0;
    logic prev_rv = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (mul_start) begin
            start_cyc = cyc;
            start_cnt++;
        end
        if (|req_ready) begin
            rdy_cnt++;
            chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
        end
        if (rst && mul_rst) mrst_cnt++;
        if (resp_valid && !prev_rv) rv_cyc = cyc;
        prev_rv = resp_valid;
        if (rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(resp_id), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_product", resp_product, e.prod);
                chk("resp_overflow", 64'(resp_overflow), 64'(e.ovf));
                chk("resp_timeout", 64'(resp_timeout), 64'(e.tmo));
            end
        end
    end

    task automatic push_exp(input int id, input logic [63:0] p, input logic o, input logic t);
        exp_t e;
        e.id = id; e.prod = p; e.ovf = o; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
    endtask

    task automatic wait_accept(output int idx, output int waited);
        idx = -1;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (|(req_ready & req_valid)) begin
                for (int j = 0; j < NR; j++) begin
                    if (req_ready[j]) idx = j;
                end
                break;
            end
        end
        if (idx < 0) chk("accept_timeout", 64'(waited), 64'd0);
    endtask

    task automatic drop(input int idx);
        @(posedge clk); #1;
        if (idx >= 0) req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_product", resp_product, 64'd0);
        chk("rst_resp_overflow", 64'(resp_overflow), 64'd0);
        chk("rst_resp_timeout", 64'(resp_timeout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_multiplicand", 64'(mul_multiplicand), 64'd0);
        chk("rst_multiplier", 64'(mul_multiplier), 64'd0);
        chk("rst_mul_rst", 64'(mul_rst), 64'd1);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic        ovf;
        int          lat;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int idx, w, s0, r0, m0;
        int order[5];
        tbl[0] = '{0, 32'd123,        32'd456,        64'd56088,                0, 1};
        tbl[1] = '{1, 32'hFFFF_FFFB,  32'd7,          64'hFFFF_FFFF_FFFF_FFDD,  0, 3};
        tbl[2] = '{2, 32'h7FFF_FFFF,  32'd2,          64'h0000_0000_FFFF_FFFE,  1, 1};
        tbl[3] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1,                    0, 5};
        tbl[4] = '{0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000,  1, 2};
        tbl[5] = '{3, 32'd0,          32'd12345,      64'd0,                    0, 1};
        order = '{0, 1, 2, 3, 0};

        req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1 rst = 1'b1;

        foreach (tbl[k]) begin
            stub_lat = tbl[k].lat;
            s0 = start_cnt; r0 = rdy_cnt;
            @(posedge clk); #1;
            send(tbl[k].id, tbl[k].a, tbl[k].b);
            push_exp(tbl[k].id, tbl[k].prod, tbl[k].ovf, 1'b0);
            wait_accept(idx, w);
            chk("table_grant", 64'(idx), 64'(tbl[k].id));
            drop(idx);
            drain();
            chk("start_pulses", 64'(start_cnt - s0), 64'd1);
            chk("ready_cycles", 64'(rdy_cnt - r0), 64'd1);
            chk("resp_latency", 64'(rv_cyc - start_cyc), 64'(tbl[k].lat + 2));
        end

        // Contention straight out of reset
        stub_lat = 1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        send(0, 32'd3, 32'd4);
        send(1, 32'hFFFF_FFFB, 32'd7);
        send(2, 32'd100, 32'hFFFF_FFFE);
        send(3, 32'd65536, 32'd65536);
        push_exp(0, 64'd12, 0, 0);
        push_exp(1, 64'hFFFF_FFFF_FFFF_FFDD, 0, 0);
        push_exp(2, 64'hFFFF_FFFF_FFFF_FF38, 0, 0);
        push_exp(3, 64'h0000_0001_0000_0000, 1, 0);
        push_exp(0, 64'd81, 0, 0);
        for (int n = 0; n < 5; n++) begin
            wait_accept(idx, w);
            chk("contention_grant", 64'(idx), 64'(order[n]));
            @(posedge clk); #1;
            if (n == 0) send(0, 32'd9, 32'd9);
            else if (idx >= 0) req_valid[idx] = 1'b0;
        end
        drain();

        // Fairness: after req2 completes, req3 wins over req1
        @(posedge clk); #1;
        send(2, 32'd2, 32'd3);
        push_exp(2, 64'd6, 0, 0);
        wait_accept(idx, w);
        drop(idx);
        drain();
        @(posedge clk); #1;
        send(1, 32'd10, 32'd10);
        send(3, 32'hFFFF_FFFF, 32'd5);
        push_exp(3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0);
        push_exp(1, 64'd100, 0, 0);
        wait_accept(idx, w);
        chk("fair_first", 64'(idx), 64'd3);
        drop(idx);
        wait_accept(idx, w);
        chk("fair_second", 64'(idx), 64'd1);
        drop(idx);
        drain();

        // Backpressure with req0 pending during RESP
        @(posedge clk); #1;
        resp_ready = 1'b0;
        send(1, 32'd11, 32'd11);
        push_exp(1, 64'd121, 0, 0);
        wait_accept(idx, w);
        drop(idx);
        send(0, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
        push_exp(0, 64'd9, 0, 0);
        for (int i = 0; i < 100 && !resp_valid; i++) @(negedge clk);
        chk("bp_resp_valid", 64'(resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_id", 64'(resp_id), 64'd1);
            chk("bp_product", resp_product, 64'd121);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        wait_accept(idx, w);
        chk("bp_grant_id", 64'(idx), 64'd0);
        chk("bp_grant_delay", 64'(w), 64'd2);
        drop(idx);
        drain();

        // Watchdog: stub never finishes
        stub_hang = 1'b1;
        m0 = mrst_cnt;
        @(posedge clk); #1;
        send(2, 32'd5, 32'd5);
        push_exp(2, 64'd0, 0, 1);
        wait_accept(idx, w);
        drop(idx);
        drain();
        chk("wd_mul_rst_cycles", 64'(mrst_cnt - m0), 64'd2);
        chk("wd_latency", 64'(rv_cyc - start_cyc), 64'(TO + 3));
        stub_hang = 1'b0;
        stub_lat = 2;
        @(posedge clk); #1;
        send(3, 32'd6, 32'd7);
        push_exp(3, 64'd42, 0, 0);
        wait_accept(idx, w);
        drop(idx);
        drain();

        // Stray done while idle is ignored
        @(posedge clk); #1 spur_done = 1'b1;
        @(posedge clk); #1 spur_done = 1'b0;
        @(negedge clk);
        chk("spur_busy", 64'(busy), 64'd0);
        chk("spur_resp_valid", 64'(resp_valid), 64'd0);

        // Reset in the middle of WAIT
        stub_lat = 10;
        @(posedge clk); #1;
        send(1, 32'd3, 32'd3);
        wait_accept(idx, w);
        drop(idx);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1 rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("mid_no_resp", 64'(resp_valid), 64'd0);
        stub_lat = 1;
        @(posedge clk); #1;
        send(0, 32'd7, 32'd6);
        push_exp(0, 64'd42, 0, 0);
        wait_accept(idx, w);
        chk("post_rst_grant", 64'(idx), 64'd0);
        drop(idx);
        drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one iterative `shift_add_multiplier` among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake, drives the multiplier's `start`/operand inputs, waits for `done` under a watchdog, and returns the result tagged with the requester index. It sits between the requesting datapath blocks and the single multiplier instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand width. Product width is 2*WIDTH.
- `TIMEOUT`, 64: maximum WAIT cycles before the watchdog aborts an operation, ≥ 4.
- `ID_W`, derived = max(1, $clog2(NUM_REQ)): local, not overridable.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept. At most one bit high.
- `req_a` in NUM_REQ*WIDTH: multiplicands; requester i at [i*WIDTH +: WIDTH].
- `req_b` in NUM_REQ*WIDTH: multipliers, same packing.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts result.
- `resp_id` out ID_W: index of the requester that owns the result.
- `resp_product` out 2*WIDTH: signed product.
- `resp_overflow` out 1: multiplier overflow flag, captured.
- `resp_timeout` out 1: operation aborted by the watchdog.
- `busy` out 1: high in any state other than IDLE.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_multiplicand` out WIDTH, `mul_multiplier` out WIDTH: operands, held stable from ISSUE through WAIT.
- `mul_product` in 2*WIDTH, `mul_done` in 1, `mul_overflow` in 1: multiplier outputs.
- `mul_rst` out 1: active-high reset to the multiplier.

## Operation
- States: IDLE, ISSUE, WAIT, RECOVER, RESP.
- IDLE:
  - Grant goes to the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap.
  - `req_ready[g]` is combinational: state==IDLE & `req_valid[g]` & grant==g.
  - On that edge, latch `req_a`/`req_b` slices and g into the op registers, then go to ISSUE.
- ISSUE: `mul_start`=1 for exactly this cycle; operands are driven from the latched registers; clear the watchdog counter; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If `mul_done`=1, capture `mul_product` and `mul_overflow`, set `resp_timeout`=0, go to RESP.
  - Else if counter == TIMEOUT-1, set the product to 0, overflow to 0, `resp_timeout`=1, and go to RECOVER.
  - If `mul_done` and the timeout occur on the same cycle, `mul_done` wins.
- RECOVER: `mul_rst`=1 for exactly 2 cycles, then RESP.
- RESP:
  - `resp_valid`=1; `resp_id`/`resp_product`/`resp_overflow`/`resp_timeout` stay stable until `resp_ready`.
  - On handshake, `rr_ptr` ← (`resp_id`+1) mod NUM_REQ, then IDLE. No new grant is issued while in RESP.
- `mul_done` outside WAIT is ignored.
- A requester must hold `req_valid` and its operands until `req_ready`. A requester dropping valid before grant is legal and is simply skipped.
- Product is passed through unmodified. The block does no sign handling; the multiplier is signed two's-complement.

## Timing
- Reset (`rst`=0), asynchronous, all of the following apply:
  - state=IDLE, `rr_ptr`=0, counter=0.
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_product`=0, `resp_overflow`=0, `resp_timeout`=0.
  - `busy`=0, `mul_start`=0, operands=0.
  - `mul_rst`=1 (combinationally follows ~`rst` OR RECOVER).
- Reset mid-operation aborts everything; no response is produced for the in-flight request.
- Accept at edge T. `mul_start` is high in cycle T+1. If `mul_done` is first seen in cycle T+1+k, `resp_valid` rises at T+2+k.
- Minimum accept-to-response is 3 cycles. Back-to-back throughput is one operation per (k+3) cycles plus the response wait.
- Timeout path: `resp_valid` rises TIMEOUT+3 cycles after ISSUE.

## Test plan
- Single op: req0 valid, a=123, b=456 → `req_ready[0]` one cycle, one `mul_start` pulse, then `resp_id`=0 and `resp_product`=56088.
- Contention: all four valid from reset with distinct operands (e.g. -5*7 on req1) → grants in order 0,1,2,3, then 0 again. req1's result is 64'hFFFF_FFFF_FFFF_FFDD.
- Round-robin fairness: after completing req2, with req1 and req3 valid → req3 is granted next, then req1.
- Backpressure: hold `resp_ready`=0 for 5 cycles with req0 pending → outputs are stable, `req_ready`=0 throughout, and the grant follows the handshake.
- Watchdog: multiplier stub never asserts done → after TIMEOUT WAIT cycles, `mul_rst` is high for 2 cycles, then `resp_timeout`=1 with `resp_product`=0. The next request completes normally.
- Reset mid-WAIT: drop `rst` for 1 cycle → all outputs take their reset values, no response is produced, and a fresh req0 7*6 returns 42.
